// File: rtl/serial_pkg.sv
// Shared UART tx types and constants for the chunk serializer.
// CHUNK_CSUM_EN adds the CSUM state used by the checksum frame.
package serial_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam int   FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef CHUNK_CSUM_EN
    , CSUM
`endif
  } tx_state_t;

  function automatic int unsigned timer_w(
    input int unsigned clks
  );
    return (clks < 3) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/chunk_serial_tx_if.sv
// Chunk input handshake: din qualified by din_valid, taken when
// din_ready is high.
interface chunk_serial_tx_if #(
  parameter int N = 30
) ();
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/uart_tx_byte.sv
// One 8N1 frame per go; a go in the last stop cycle chains
// the next frame with no idle gap.
module uart_tx_byte
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] byte_in,
  output logic       txd,
  output logic       byte_done
);

  localparam int TW = timer_w(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] LAST_T = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_d;
  logic          tick;

  assign tick = (timer_q == LAST_T);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = START;
          timer_d = '0;
          shreg_d = byte_in;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          timer_d = '0;
          bit_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          timer_d = '0;
          if (bit_q == LAST_B) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          byte_done = 1'b1;
          timer_d   = '0;
          if (go) begin
            state_d = START;
            shreg_d = byte_in;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the next state to keep txd glitch-free.
  always_comb begin
    txd_d = STOP_LVL;
    unique case (state_d)
      START:   txd_d = START_LVL;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = STOP_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd     <= STOP_LVL;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd     <= txd_d;
    end
  end

endmodule

// File: rtl/chunk_serial_tx.sv
// Splits an N-bit chunk into COUNT bytes, MSB byte first, over 8N1.
// CHUNK_CSUM_EN appends an XOR checksum frame after the data bytes.
module chunk_serial_tx
  import serial_pkg::*;
#(
  parameter int N            = 30,
  parameter int COUNT        = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  chunk_serial_tx_if.slave din_if,
  output logic        txD,
  output logic        busy,
  output logic        done,
  output logic [31:0] counter
);

  localparam int W  = COUNT * 8;
  localparam int IW = $clog2(COUNT + 1);

  tx_state_t     phase_q, phase_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  ext;
  logic [7:0]    byte_in;
  logic          go, byte_done, fin, accept;
`ifdef CHUNK_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  assign ext              = W'(din_if.din);
  assign din_if.din_ready = (phase_q == IDLE);
  assign busy             = (phase_q != IDLE);
  assign accept           = din_if.din_valid & din_if.din_ready;

  always_comb begin
    phase_d = phase_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    go      = 1'b0;
    fin     = 1'b0;
    byte_in = sreg_q[W-1 -: 8];
`ifdef CHUNK_CSUM_EN
    csum_d  = csum_q;
`endif
    unique case (phase_q)
      IDLE: begin
        // First byte goes straight from din so the start bit is not delayed.
        if (accept) begin
          go      = 1'b1;
          byte_in = ext[W-1 -: 8];
          sreg_d  = ext << 8;
          idx_d   = IW'(1);
          phase_d = DATA;
`ifdef CHUNK_CSUM_EN
          csum_d  = ext[W-1 -: 8];
`endif
        end
      end
      DATA: begin
        if (byte_done) begin
          if (idx_q == IW'(COUNT)) begin
`ifdef CHUNK_CSUM_EN
            go      = 1'b1;
            byte_in = csum_q;
            phase_d = CSUM;
`else
            fin     = 1'b1;
            phase_d = IDLE;
`endif
          end else begin
            go     = 1'b1;
            sreg_d = sreg_q << 8;
            idx_d  = idx_q + 1'b1;
`ifdef CHUNK_CSUM_EN
            csum_d = csum_q ^ sreg_q[W-1 -: 8];
`endif
          end
        end
      end
`ifdef CHUNK_CSUM_EN
      CSUM: begin
        if (byte_done) begin
          fin     = 1'b1;
          phase_d = IDLE;
        end
      end
`endif
      default: phase_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      done    <= 1'b0;
      counter <= '0;
`ifdef CHUNK_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      phase_q <= phase_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      done    <= fin;
      if (fin) counter <= counter + 32'd1;
`ifdef CHUNK_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .byte_in  (byte_in),
    .txd      (txD),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_chunk_serial_tx.sv
// Randomized bench for chunk_serial_tx against a per-cycle line model.
// Build with +define+CHUNK_CSUM_EN to cover the checksum frame.
module tb_chunk_serial_tx;
  import serial_pkg::*;

  localparam int N     = 30;
  localparam int COUNT = 4;
  localparam int C     = 4;
  localparam int W     = COUNT * 8;
`ifdef CHUNK_CSUM_EN
  localparam int FRAMES = COUNT + 1;
`else
  localparam int FRAMES = COUNT;
`endif
  localparam int LAT = FRAMES * FRAME_BITS * C + 1;

  typedef struct packed {
    logic txd;
    logic last;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        txD, busy, done;
  logic [31:0] counter;

  chunk_serial_tx_if #(.N(N)) bus ();

  chunk_serial_tx #(
    .N(N), .COUNT(COUNT), .CLKS_PER_BIT(C)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .din_if (bus.slave),
    .txD    (txD),
    .busy   (busy),
    .done   (done),
    .counter(counter)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  ent_t        line_q[$];
  logic        known = 1'b0;
  logic        m_txd, m_busy, m_done, pend;
  logic [31:0] m_cnt;
  logic        saw_done;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b,
                            input logic last_frame);
    ent_t e;
    for (int k = 0; k < FRAME_BITS; k++) begin
      for (int r = 0; r < C; r++) begin
        if (k == 0) e.txd = START_LVL;
        else if (k == FRAME_BITS - 1) e.txd = STOP_LVL;
        else e.txd = b[k-1];
        e.last = last_frame && (k == FRAME_BITS - 1) && (r == C - 1);
        line_q.push_back(e);
      end
    end
  endtask

  task automatic push_chunk(input logic [N-1:0] d);
    logic [W-1:0] ext;
    logic [7:0]   b, x;
    ext = W'(d);
    x   = 8'h00;
    for (int k = 0; k < COUNT; k++) begin
      b = 8'(ext >> ((COUNT - 1 - k) * 8));
      x = x ^ b;
      push_frame(b, (k == FRAMES - 1));
    end
`ifdef CHUNK_CSUM_EN
    push_frame(x, 1'b1);
`endif
  endtask

  // Advances the model across the clock edge that samples these inputs.
  task automatic model_edge(input logic v, input logic [N-1:0] d,
                            input logic r);
    ent_t e;
    if (r) begin
      line_q.delete();
      pend   = 1'b0;
      m_txd  = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = '0;
      known  = 1'b1;
    end else if (known) begin
      if (v && !m_busy) push_chunk(d);
      m_done = pend;
      if (pend) m_cnt = m_cnt + 32'd1;
      if (line_q.size() > 0) begin
        e      = line_q.pop_front();
        m_txd  = e.txd;
        m_busy = 1'b1;
        pend   = e.last;
      end else begin
        m_txd  = 1'b1;
        m_busy = 1'b0;
        pend   = 1'b0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [N-1:0] d,
                      input logic r);
    @(negedge clk);
    if (known) begin
      check("txD", 32'(txD), 32'(m_txd));
      check("busy", 32'(busy), 32'(m_busy));
      check("din_ready", 32'(bus.din_ready), 32'(!m_busy));
      check("done", 32'(done), 32'(m_done));
      check("counter", counter, m_cnt);
    end
    if (done === 1'b1) saw_done = 1'b1;
    bus.din_valid = v;
    bus.din       = d;
    reset         = r;
    model_edge(v, d, r);
  endtask

  function automatic logic [N-1:0] rnd();
    return N'({$urandom, $urandom});
  endfunction

  initial begin
    int lat;
    reset         = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    saw_done      = 1'b0;

    repeat (3) step(1'b1, rnd(), 1'b1);
    repeat (4) step(1'b0, rnd(), 1'b0);

    step(1'b1, 30'h2345_6789, 1'b0);
    saw_done = 1'b0;
    lat      = 0;
    for (int i = 1; i <= 2 * LAT; i++) begin
      step(1'b0, rnd(), 1'b0);
      if (saw_done) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'(LAT));
    check("count1", counter, 32'd1);

    repeat (2 * LAT + 10) step(1'b1, rnd(), 1'b0);
    repeat (5) step(1'b0, rnd(), 1'b0);

    step(1'b1, rnd(), 1'b0);
    repeat (50) step(1'b0, rnd(), 1'b0);
    step(1'b1, 30'h3FFF_FFFF, 1'b0);
    repeat (LAT) step(1'b0, rnd(), 1'b0);

    step(1'b1, rnd(), 1'b0);
    repeat (FRAME_BITS * C + 3 * C + 2) step(1'b0, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b1);
    step(1'b1, rnd(), 1'b0);
    repeat (LAT + 5) step(1'b0, rnd(), 1'b0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, rnd(),
           $urandom_range(0, 1499) == 0);
    repeat (LAT + 5) step(1'b0, rnd(), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
